// File: rtl/uart_tx_param_if.sv
// Transmit-side handshake and serial line bundle for uart_tx_param.
// master = word producer, slave = the transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 send_data;
  logic [DATA_BITS-1:0] inp_data;
  logic [1:0]           parity_type;
  logic                 stop_bits;
  logic                 ready;
  logic                 busy;
  logic                 tx_done;
  logic                 output_data_serial;

  modport master (
    output send_data, inp_data, parity_type, stop_bits,
    input  ready, busy, tx_done, output_data_serial
  );

  modport slave (
    input  send_data, inp_data, parity_type, stop_bits,
    output ready, busy, tx_done, output_data_serial
  );
endinterface

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx_param #(
  parameter int CLOCKS_PER_BIT = 434,
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_param_if.slave bus
);
  localparam int CNT_W = $clog2(2 * CLOCKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int ENT_W = DATA_BITS + 3;
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP2_LAST = CNT_W'(2 * CLOCKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic             push, pop, buf_full, buf_empty;
  logic [ENT_W-1:0] wr_ent, rd_ent;

  // Entry layout: {stop_bits, parity_type, data} so each frame keeps its own format.
  assign wr_ent = {bus.stop_bits, bus.parity_type, bus.inp_data};
  assign push   = bus.send_data && !buf_full;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  assign rd_ent    = mem[rd_ptr];
  assign buf_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign buf_empty = (count == '0);
`else
  logic [ENT_W-1:0] hold;
  logic             hold_vld;
  logic             unused_depth;

  assign unused_depth = FIFO_DEPTH[0];

  always_ff @(posedge clk) begin
    if (!rst)      hold_vld <= 1'b0;
    else if (push) hold_vld <= 1'b1;
    else if (pop)  hold_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) hold <= wr_ent;
  end

  assign rd_ent    = hold;
  assign buf_full  = hold_vld;
  assign buf_empty = !hold_vld;
`endif

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [BIT_W-1:0]       bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   sh, sh_n;
  logic                   par_bit, par_n;
  logic                   par_en, par_en_n;
  logic                   stop2, stop2_n;
  logic                   line_q, line_n;
  logic [CNT_W-1:0]       stop_last;

  assign stop_last = stop2 ? STOP2_LAST : BIT_LAST;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      line_q  <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      line_q  <= line_n;
    end
  end

  always_ff @(posedge clk) begin
    sh      <= sh_n;
    par_bit <= par_n;
    par_en  <= par_en_n;
    stop2   <= stop2_n;
  end

  // line_n is the level for the state being entered, so the line flop tracks the FSM with no lag.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_cnt;
    sh_n     = sh;
    par_n    = par_bit;
    par_en_n = par_en;
    stop2_n  = stop2;
    line_n   = 1'b1;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!buf_empty) begin
          pop      = 1'b1;
          sh_n     = rd_ent[DATA_BITS-1:0];
          par_en_n = rd_ent[DATA_BITS] ^ rd_ent[DATA_BITS+1];
          // Odd mode (01) inverts the XOR-reduce, even mode (10) uses it directly.
          par_n    = (^rd_ent[DATA_BITS-1:0]) ^ rd_ent[DATA_BITS];
          stop2_n  = rd_ent[DATA_BITS+2];
          cnt_n    = '0;
          bit_n    = '0;
          state_n  = START;
          line_n   = 1'b0;
        end
      end
      START: begin
        line_n = 1'b0;
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = DATA;
          line_n  = sh[0];
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        line_n = sh[0];
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (bit_cnt == DATA_LAST) begin
            if (par_en) begin
              state_n = PARITY;
              line_n  = par_bit;
            end else begin
              state_n = STOP;
              line_n  = 1'b1;
            end
          end else begin
            bit_n  = bit_cnt + BIT_W'(1);
            sh_n   = sh >> 1;
            line_n = sh[1];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        line_n = par_bit;
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = STOP;
          line_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        line_n = 1'b1;
        if (cnt == stop_last) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.ready              = !buf_full;
  assign bus.busy               = (state != IDLE) || !buf_empty;
  assign bus.tx_done            = (state == STOP) && (cnt == stop_last);
  assign bus.output_data_serial = line_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Randomised bench for uart_tx_param against a per-cycle line waveform model.
// Works in both buffer builds (UART_TX_FIFO_EN defined or not).
module tb_uart_tx_param;
  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 8;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic          s;
    logic [1:0]    p;
    logic [DB-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(DB)) bus();

  uart_tx_param #(
    .CLOCKS_PER_BIT(CPB),
    .DATA_BITS     (DB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ent_t mbuf[$];
  bit   wave[$];
  bit   active;
  bit   exp_line, exp_done, exp_busy, exp_ready;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expands one word into its line levels: start, data LSB first, parity, stop(s).
  task automatic frame(input ent_t e);
    bit lvl[$];
    lvl.push_back(1'b0);
    for (int i = 0; i < DB; i++) lvl.push_back(e.d[i]);
    if (e.p == 2'd1) lvl.push_back(~^e.d);
    else if (e.p == 2'd2) lvl.push_back(^e.d);
    lvl.push_back(1'b1);
    if (e.s) lvl.push_back(1'b1);
    foreach (lvl[k]) repeat (CPB) wave.push_back(lvl[k]);
  endtask

  // Predicts the outputs for the cycle following this rising edge.
  task automatic model_step(input bit r, input bit snd, input ent_t e);
    bit acc;
    if (!r) begin
      mbuf.delete();
      wave.delete();
      active    = 1'b0;
      exp_line  = 1'b1;
      exp_done  = 1'b0;
      exp_busy  = 1'b0;
      exp_ready = 1'b1;
      return;
    end
    acc = snd && (mbuf.size() < CAP);
    if (!active && mbuf.size() > 0) frame(mbuf.pop_front());
    if (acc) mbuf.push_back(e);
    if (wave.size() > 0) begin
      exp_line = wave.pop_front();
      active   = 1'b1;
      exp_done = (wave.size() == 0);
    end else begin
      exp_line = 1'b1;
      active   = 1'b0;
      exp_done = 1'b0;
    end
    exp_busy  = active || (mbuf.size() > 0);
    exp_ready = (mbuf.size() < CAP);
  endtask

  task automatic cyc(input bit r, input bit snd, input logic [DB-1:0] d,
                     input logic [1:0] p, input bit s);
    ent_t e;
    e = '{s: s, p: p, d: d};
    rst               = r;
    bus.send_data     = snd;
    bus.inp_data      = d;
    bus.parity_type   = p;
    bus.stop_bits     = s;
    @(posedge clk);
    model_step(r, snd, e);
    @(negedge clk);
    chk("line",    bus.output_data_serial, exp_line);
    chk("tx_done", bus.tx_done,            exp_done);
    chk("busy",    bus.busy,               exp_busy);
    chk("ready",   bus.ready,              exp_ready);
  endtask

  // Idle cycles with the word/format inputs scrambled to show frames are latched.
  task automatic idle(input int n);
    logic [DB-1:0] d;
    logic [1:0]    p;
    for (int i = 0; i < n; i++) begin
      d = DB'($urandom);
      p = 2'($urandom);
      cyc(1'b1, 1'b0, d, p, 1'($urandom));
    end
  endtask

  initial begin
    logic [DB-1:0] d;
    logic [1:0]    p;
    bit            s, snd, r;

    active = 1'b0;
    repeat (3) cyc(1'b0, 1'b1, 8'h3C, 2'd1, 1'b1);

    cyc(1'b1, 1'b1, 8'hA5, 2'd0, 1'b0);
    idle(50);
    cyc(1'b1, 1'b1, 8'h07, 2'd1, 1'b0);
    idle(50);
    cyc(1'b1, 1'b1, 8'h07, 2'd2, 1'b0);
    idle(50);
    cyc(1'b1, 1'b1, 8'h5A, 2'd3, 1'b1);
    idle(60);

    cyc(1'b1, 1'b1, 8'hFF, 2'd2, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, DB'(8'h10 + i), 2'(i), 1'(i));
    idle(500);

    cyc(1'b1, 1'b1, 8'hC3, 2'd1, 1'b0);
    idle(10);
    cyc(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    idle(2);
    cyc(1'b1, 1'b1, 8'h96, 2'd2, 1'b1);
    idle(60);

    for (int i = 0; i < 3000; i++) begin
      d   = DB'($urandom);
      p   = 2'($urandom);
      s   = 1'($urandom);
      snd = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 999) != 0);
      cyc(r, snd, d, p, s);
    end
    idle(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 434: clock cycles per serial bit, legal range >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries, power of two >= 2.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port send_data  input  1  write strobe; byte accepted on a cycle where send_data=1 and ready=1.
REQ-007 SHALL have port inp_data  input  DATA_BITS  word to transmit, sampled on acceptance.
REQ-008 SHALL have port parity_type  input  2  0 none, 1 odd, 2 even, 3 none; sampled per frame.
REQ-009 SHALL have port stop_bits  input  1  0 one stop bit, 1 two stop bits; sampled per frame.
REQ-010 SHALL have port ready  output  1  1 when a write will be accepted.
REQ-011 SHALL have port busy  output  1  1 whenever a frame is on the line or data is buffered.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse at end of each frame.
REQ-013 SHALL have port output_data_serial  output  1  registered serial line, idle high.

Function
REQ-014 SHALL store each accepted word together with its parity_type and stop_bits in the buffer (REQ-030).
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: line high; if buffer non-empty, pop one entry into the shift/config registers and go to START.
REQ-017 START: line 0 for exactly CLOCKS_PER_BIT cycles, then DATA.
REQ-018 DATA: DATA_BITS bits LSB first, each exactly CLOCKS_PER_BIT cycles; after the last bit go to PARITY if parity mode 1 or 2, otherwise go to STOP.
REQ-019 PARITY: one bit of CLOCKS_PER_BIT cycles; odd = NOT XOR-reduce(data), even = XOR-reduce(data).
REQ-020 STOP: line 1 for CLOCKS_PER_BIT cycles (one stop bit) or 2*CLOCKS_PER_BIT cycles (two stop bits), then IDLE.
REQ-021 tx_done SHALL be 1 in the final cycle of STOP only.
REQ-022 Latency: write accepted in cycle N with buffer empty and state IDLE -> line goes low in cycle N+2.
REQ-023 Back-to-back: exactly one IDLE cycle (line high) between the end of STOP and the next START.
REQ-024 ready = NOT full; a write while full SHALL be dropped with no state change, even if a pop occurs in the same cycle.
REQ-025 A write to an empty buffer in the same cycle IDLE samples it SHALL be popped in the following cycle, not lost.
REQ-026 busy = (state != IDLE) OR buffer non-empty.
REQ-027 Changes to inp_data, parity_type or stop_bits SHALL NOT affect any frame already accepted.
REQ-028 Bit counter and clock counter SHALL be wide enough for DATA_BITS and 2*CLOCKS_PER_BIT with no wrap-around.

Reset
REQ-029 While rst=0 at a clock edge: state IDLE, buffer emptied, counters 0, output_data_serial=1, ready=1, busy=0, tx_done=0; a frame in progress is aborted and the line returns high in the next cycle.

Configuration
REQ-030 Macro UART_TX_FIFO_EN defined: buffer is a FIFO of FIFO_DEPTH entries. Macro not defined: buffer is a single holding register, so ready=0 from acceptance until the pop in IDLE; FIFO_DEPTH is ignored. All other requirements hold in both builds.

Verification (CLOCKS_PER_BIT=4, DATA_BITS=8 unless noted)
REQ-031 Write 0xA5, parity 0, one stop bit -> line 0,1,0,1,0,0,1,0,1,1 in 4-cycle bit slots; low at N+2; tx_done in the final stop cycle.
REQ-032 Write 0x07 with parity 1, then with parity 2 -> parity bit 0, then 1; frame 11 bits long.
REQ-033 stop_bits=1 -> high stop period of 8 cycles; tx_done in its last cycle.
REQ-034 FIFO build: 9 consecutive writes with depth 8 and line busy -> ready falls after the 8th entry is buffered, the 9th write is dropped, 8 frames are sent with one idle cycle between them, and busy falls after the last tx_done.
REQ-035 Non-FIFO build: second write during a frame -> ready=0 and the second write is dropped; a write after the pop is accepted.
REQ-036 rst=0 during DATA -> line 1, busy=0, ready=1 next cycle; a new write afterwards produces a clean frame.
